// File: rtl/alu_master_if.sv
// Request/response port and ALU command bus for alu_master.
// The master modport is the sequencer side; slave is the host plus ALU side.
interface alu_master_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_a;
    logic [7:0]  req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic        alu_start;
    logic [1:0]  alu_op;
    logic [7:0]  alu_inbus;
    logic [7:0]  alu_outbus;
    logic        alu_finish;

    modport master (
        input  req_valid, req_op, req_a, req_b, rsp_ready, alu_outbus, alu_finish,
        output req_ready, rsp_valid, rsp_data, rsp_err, busy, alu_start, alu_op, alu_inbus
    );

    modport slave (
        output req_valid, req_op, req_a, req_b, rsp_ready, alu_outbus, alu_finish,
        input  req_ready, rsp_valid, rsp_data, rsp_err, busy, alu_start, alu_op, alu_inbus
    );
endinterface

// File: rtl/alu_master.sv
// Drives one ALU transaction per accepted request: start pulse, byte-serial
// operands, then collects the two-byte result and offers it on the response port.
//
// state | meaning
// IDLE  | ready for a request, ALU bus parked at 0
// START | one-cycle alu_start pulse
// OP1   | first operand byte (A hi for div, else A lo)
// OP2   | second operand byte (A lo for div, else B)
// OP3   | divisor byte, div only
// WAIT  | waiting for alu_finish, timeout counter running
// CAPLO | capture result low byte
// RESP  | result held until rsp_ready
module alu_master #(
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    alu_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, START, OP1, OP2, OP3, WAIT, CAPLO, RESP} state_t;

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TC = CW'(TIMEOUT - 1);

    state_t          state, state_d;
    logic [1:0]      op_q;
    logic [15:0]     a_q;
    logic [7:0]      b_q;
    logic [CW-1:0]   cnt;
    logic [15:0]     data_q;
    logic            err_q;
    logic            is_div;
    logic            cnt_tc;

    assign is_div = (op_q == 2'b11);
    assign cnt_tc = (cnt == TC);
    assign bus.rsp_data = data_q;
    assign bus.rsp_err  = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    always_comb begin
        state_d       = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.busy      = (state != IDLE);
        bus.alu_start = 1'b0;
        bus.alu_op    = 2'b00;
        bus.alu_inbus = 8'h00;
        case (state)
            IDLE: begin
                bus.req_ready = rst;
                if (bus.req_valid) state_d = START;
            end
            START: begin
                bus.alu_start = 1'b1;
                bus.alu_op    = op_q;
                state_d       = OP1;
            end
            OP1: begin
                bus.alu_op    = op_q;
                bus.alu_inbus = is_div ? a_q[15:8] : a_q[7:0];
                state_d       = OP2;
            end
            OP2: begin
                bus.alu_op    = op_q;
                bus.alu_inbus = is_div ? a_q[7:0] : b_q;
                state_d       = is_div ? OP3 : WAIT;
            end
            OP3: begin
                bus.alu_op    = op_q;
                bus.alu_inbus = b_q;
                state_d       = WAIT;
            end
            WAIT: begin
                // B is the last byte sent for every op, so it is what stays on the bus
                bus.alu_op    = op_q;
                bus.alu_inbus = b_q;
                if (bus.alu_finish) state_d = CAPLO;
                else if (cnt_tc)    state_d = RESP;
            end
            CAPLO: begin
                bus.alu_op    = op_q;
                bus.alu_inbus = b_q;
                state_d       = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q   <= 2'b00;
            a_q    <= 16'h0000;
            b_q    <= 8'h00;
            cnt    <= '0;
            data_q <= 16'h0000;
            err_q  <= 1'b0;
        end else begin
            if (state == IDLE && bus.req_valid) begin
                op_q <= bus.req_op;
                a_q  <= bus.req_a;
                b_q  <= bus.req_b;
            end
            if (state != WAIT) begin
                cnt <= '0;
            end else if (bus.alu_finish) begin
                data_q[15:8] <= bus.alu_outbus;
            end else if (cnt_tc) begin
                data_q <= 16'h0000;
                err_q  <= 1'b1;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (state == CAPLO) begin
                data_q[7:0] <= bus.alu_outbus;
                err_q       <= 1'b0;
            end
        end
    end
endmodule

// File: doc/alu_master.md
# alu_master

Synthesizable initiator for the 8-bit ALU (`top_level`) command protocol: start pulse, byte-serial operands on `inbus`, two-byte result on `outbus` after `finish`. It accepts one ready/valid request (op plus operands), sequences the ALU through a transaction, and returns the 16-bit result on a ready/valid response port. It sits between a host or controller and the ALU, replacing bench-driven stimulus in system builds.

## Interface
- `TIMEOUT`, default 64 — maximum cycles spent in WAIT before the transaction is aborted (legal range ≥ 2).
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — asynchronous, active-low reset.
- `req_valid` in 1 — request present.
- `req_ready` out 1 — block can accept a request.
- `req_op` in 2 — 00 add, 01 sub, 10 mul, 11 div.
- `req_a` in 16 — operand A. For op 11, the full 16-bit dividend; otherwise only `[7:0]` is used.
- `req_b` in 8 — operand B, or the divisor for op 11.
- `rsp_valid` out 1 — result held.
- `rsp_ready` in 1 — consumer takes the result.
- `rsp_data` out 16 — `{hi, lo}`. For div this is `{quotient, remainder}`.
- `rsp_err` out 1 — qualifies `rsp_data`; 1 means timeout.
- `busy` out 1 — asserted whenever the state is not IDLE.
- `alu_start` out 1 — to ALU `start`.
- `alu_op` out 2 — to ALU `op`.
- `alu_inbus` out 8 — to ALU `inbus`.
- `alu_outbus` in 8 — from ALU `outbus`.
- `alu_finish` in 1 — from ALU `finish`.

## Operation
- States: IDLE, START, OP1, OP2, OP3, WAIT, CAPLO, RESP.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid`, latch `req_op`, `req_a` and `req_b` into internal registers, then go to START.
- START:
  - `alu_start` = 1 for exactly one cycle.
  - `alu_op` = latched op; it is held through CAPLO.
  - Next state is OP1.
- OP1: `alu_inbus` = `A[15:8]` for div, `A[7:0]` for all other ops. Next state is OP2.
- OP2:
  - `alu_inbus` = `A[7:0]` for div, `B` for all other ops.
  - Next state is OP3 for div, WAIT otherwise.
- OP3 (div only): `alu_inbus` = `B`. Next state is WAIT.
- `alu_inbus` holds its last operand value through WAIT and CAPLO. It returns to 0 in IDLE.
- WAIT:
  - `alu_finish` is sampled on each edge, with a timeout counter cleared on WAIT entry.
  - If `alu_finish` = 1: capture `alu_outbus` into `hi` and go to CAPLO.
  - Else if the counter equals `TIMEOUT`-1: set `rsp_err` = 1, set `rsp_data` = 0, and go to RESP.
  - Otherwise, increment the counter.
- CAPLO: capture `alu_outbus` into `lo`, clear `rsp_err`, and go to RESP.
- RESP:
  - `rsp_valid` = 1.
  - `rsp_data` and `rsp_err` stay stable until the handshake.
  - On `rsp_ready`, go to IDLE.
- The block does not interpret the result bytes; sign and width come from the ALU.
- `alu_finish` seen in START or OP1..OP3 is ignored. The finish is sampled only in WAIT.

## Timing
- Reset values: `req_ready` = 0 while `rst` = 0, then 1 in IDLE. `rsp_valid`, `rsp_err`, `busy`, `alu_start` and `alu_op` = 0; `alu_inbus` = 0; `rsp_data` = 0; state = IDLE; counter = 0.
- Accept edge E0 (IDLE with `req_valid`):
  - `alu_start` is high between E0 and E1.
  - Byte 1 is driven E1–E2, byte 2 E2–E3, byte 3 (div only) E3–E4.
  - WAIT begins at E3 (non-div) or E4 (div).
- Let Ef be the first WAIT edge that samples `alu_finish` = 1:
  - `hi` = `alu_outbus` at Ef.
  - `lo` = `alu_outbus` at Ef+1.
  - `rsp_valid` rises after Ef+1.
- Minimum request-to-response latency, with finish already high on the first WAIT edge: 5 cycles for non-div, 6 for div.
- `rsp_valid` and `rsp_ready` both high on an edge: handshake completes, state goes to IDLE, and `req_ready` = 1 on the next cycle. Back-to-back throughput is one transaction per at least 7 cycles.
- Requests are never accepted outside IDLE. `req_valid` in any other state is held off.
- Timeout: with finish never high, `rsp_valid` rises exactly `TIMEOUT` cycles after WAIT entry.
- Reset mid-transaction:
  - Returns immediately to the reset values.
  - Any captured result is discarded and no response is issued.
  - The ALU must share the same reset.

## Test plan
- Add, with the real `top_level` attached: A = 100, B = 27, op 00 → `rsp_data` = 16'h007F, `rsp_err` = 0. `alu_start` is high for exactly 1 cycle and the bytes appear in order 100, 27.
- Sub: A = 3, B = 5, op 01 → `rsp_data` = 16'hFFFE. Mul: A = 200, B = 3, op 10 → `rsp_data` = 16'h0258.
- Div: A = 16'd1000, B = 7, op 11 → the bytes driven are 8'h03, 8'hE8, 8'h07, and `rsp_data` = 16'h8E06 (quotient 142, remainder 6).
- Timeout: `alu_finish` tied 0, `TIMEOUT` = 16 → `rsp_valid` rises 16 cycles after WAIT entry, with `rsp_err` = 1 and `rsp_data` = 0.
- Backpressure:
  - Hold `rsp_ready` = 0 for 5 cycles after `rsp_valid` → `rsp_data` stays stable and `req_ready` stays 0.
  - A request presented meanwhile is accepted only in the cycle after the handshake.
- Reset pulse during WAIT → all outputs go to reset values asynchronously, and no `rsp_valid` appears.
- After reset release, a new add of 1 + 1 returns 16'h0002.
